i2s_axil_regs_slave: RTL

AXI4-Lite responder (slave) register block for the I2S data path: the target end of the CPU/VIP master's AXI4LITE write/read transactions. It holds a control register and a 4-deep TX sample FIFO feeding the I2S transmitter. It also provides a single-entry RX sample holding register filled by the I2S receiver, and a status register. It sits between the PS AXI interconnect and the I2S serializer/deserializer.

---
 rtl/i2s_axil_regs_slave.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_axil_regs_slave.sv
// AXI4-Lite register slave for the I2S data path: CTRL register, TX sample FIFO,
// single-entry RX holding register and STATUS register.
module i2s_axil_regs_slave #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned TX_FIFO_DEPTH      = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                        s_axi_awprot,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                        s_axi_arprot,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic [31:0]                       ctrl,
   output logic [31:0]                       tx_sample,
   output logic                              tx_valid,
   input  logic                              tx_ready,
   input  logic [31:0]                       rx_sample,
   input  logic                              rx_valid
);

   localparam int unsigned PtrW = $clog2(TX_FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   logic             r_awready, r_wready, r_bvalid;
   logic [1:0]       r_bresp;
   logic             r_arready, r_rvalid;
   logic [1:0]       r_rresp;
   logic [31:0]      r_rdata;
   logic [31:0]      r_ctrl, r_tx_last, r_rx_data;
   logic             r_rx_pending, r_overrun;
   logic [31:0]      r_mem [TX_FIFO_DEPTH];
   logic [PtrW-1:0]  r_wptr, r_rptr;
   logic [CntW-1:0]  r_count;

   logic             w_wr_start, w_wr_fire, w_rd_start, w_rd_fire;
   logic [1:0]       w_wr_sel, w_rd_sel;
   logic             w_full, w_empty, w_push_req, w_push, w_pop;
   logic             w_rx_rd, w_ovr_set, w_ovr_clr;
   logic [3:0]       w_level;
   logic [31:0]      w_status, w_rd_data;
   logic [1:0]       w_rd_resp;
   logic             w_unused_ok;

   // Protection bits and byte-offset address bits carry no meaning here
   assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign w_wr_sel   = s_axi_awaddr[3:2];
   assign w_rd_sel   = s_axi_araddr[3:2];
   assign w_wr_start = s_axi_awvalid && s_axi_wvalid && !r_bvalid && !r_awready;
   assign w_wr_fire  = r_awready && s_axi_awvalid && s_axi_wvalid;
   assign w_rd_start = s_axi_arvalid && !r_rvalid && !r_arready;
   assign w_rd_fire  = r_arready && s_axi_arvalid;

   // Full is judged on the count before this cycle's pop
   assign w_full     = (r_count == CntW'(TX_FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push_req = w_wr_fire && (w_wr_sel == 2'd1);
   assign w_push     = w_push_req && !w_full;
   assign w_pop      = !w_empty && tx_ready;
   assign w_level    = 4'(r_count);

   assign w_rx_rd    = w_rd_fire && (w_rd_sel == 2'd2);
   // A read accepted in the same cycle hands the old sample out, so no overrun
   assign w_ovr_set  = rx_valid && r_rx_pending && !w_rx_rd;
   assign w_ovr_clr  = w_wr_fire && (w_wr_sel == 2'd3) && s_axi_wstrb[1] && s_axi_wdata[9];

   assign w_status = {22'd0, r_overrun, r_rx_pending, 2'b00, w_empty, w_full, w_level};

   // Read data mux from pre-cycle state
   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RespOkay;
      unique case (w_rd_sel)
         2'd0: w_rd_data = r_ctrl;
         2'd1: w_rd_data = r_tx_last;
         2'd2: begin
            if (r_rx_pending) w_rd_data = r_rx_data;
            else              w_rd_resp = RespSlverr;
         end
         2'd3: w_rd_data = w_status;
         default: ;
      endcase
   end

   // Write address/data handshake and B channel
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RespOkay;
      end else begin
         r_awready <= w_wr_start;
         r_wready  <= w_wr_start;
         if (w_wr_fire) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_push_req && w_full) ? RespSlverr : RespOkay;
         end else if (r_bvalid && s_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read address handshake and R channel
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RespOkay;
      end else begin
         r_arready <= w_rd_start;
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
         end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // CTRL register with byte strobes, and last-pushed TX word
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_ctrl    <= '0;
         r_tx_last <= '0;
      end else begin
         if (w_wr_fire && (w_wr_sel == 2'd0)) begin
            for (int b = 0; b < 4; b++) begin
               if (s_axi_wstrb[b]) r_ctrl[8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
         end
         if (w_push) r_tx_last <= s_axi_wdata;
      end
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // TX FIFO storage; contents are meaningless once the pointers reset
   always_ff @(posedge ACLK) begin
      if (w_push) r_mem[r_wptr] <= s_axi_wdata;
   end

   // RX holding register, pending flag and sticky overrun
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rx_data    <= '0;
         r_rx_pending <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (rx_valid) begin
            r_rx_data    <= rx_sample;
            r_rx_pending <= 1'b1;
         end else if (w_rx_rd) begin
            r_rx_pending <= 1'b0;
         end
         if (w_ovr_set)      r_overrun <= 1'b1;
         else if (w_ovr_clr) r_overrun <= 1'b0;
      end
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign ctrl          = r_ctrl;
   assign tx_sample     = r_mem[r_rptr];
   assign tx_valid      = !w_empty;

endmodule
